// File: rtl/led_sequencer.sv
// led_sequencer: display stage behind the game controller.
// Shows each accepted colour for a speed-dependent on-time followed by a
// blank gap. It also plays the all-LED blink pattern requested on
// victory/defeat. Completion is reported with a one-cycle done pulse.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   speed       0 = slow, 1 = fast; sampled only when an item is accepted
//   show_valid  controller presents an item
//   show_item   colour pattern to display
//   show_ready  high while idle (item can be accepted)
//   flash_req   request the all-LED blink pattern (wins over show_valid)
//   busy        high in any state other than idle
//   done        one-cycle pulse when a show or flash sequence completes
//   leds        registered LED drive
module led_sequencer #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned ON_CYCLES_SLOW = 12_000_000,
  parameter int unsigned ON_CYCLES_FAST = 6_000_000,
  parameter int unsigned GAP_CYCLES     = 3_000_000,
  parameter int unsigned FLASH_CYCLES   = 6_000_000,
  parameter int unsigned FLASH_COUNT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  speed,
  input  logic                  show_valid,
  input  logic [DATA_WIDTH-1:0] show_item,
  output logic                  show_ready,
  input  logic                  flash_req,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] leds
);

  localparam int unsigned PAIR_W = $clog2(FLASH_COUNT + 1);

  // Counter reload values: a phase ends when cnt is 0 at an edge, so
  // loading duration-1 makes each phase last exactly its duration.
  localparam logic [CNT_WIDTH-1:0] LD_SLOW  = CNT_WIDTH'(ON_CYCLES_SLOW - 1);
  localparam logic [CNT_WIDTH-1:0] LD_FAST  = CNT_WIDTH'(ON_CYCLES_FAST - 1);
  localparam logic [CNT_WIDTH-1:0] LD_GAP   = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LD_FLASH = CNT_WIDTH'(FLASH_CYCLES - 1);
  localparam logic [PAIR_W-1:0]    PAIRS    = PAIR_W'(FLASH_COUNT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHOW_ON   = 3'd1,
    SHOW_GAP  = 3'd2,
    FLASH_ON  = 3'd3,
    FLASH_OFF = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PAIR_W-1:0]     pair_q, pair_d;
  logic [DATA_WIDTH-1:0] leds_q, leds_d;
  logic                  done_q, done_d;
  logic                  expired;

  assign expired = (cnt_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pair_q  <= '0;
      leds_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    leds_d  = leds_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        leds_d = '0;
        if (flash_req) begin
          state_d = FLASH_ON;
          leds_d  = '1;
          cnt_d   = LD_FLASH;
          pair_d  = PAIR_W'(1);
        end else if (show_valid) begin
          // The item and its on-time are captured here; later speed
          // changes cannot affect the item in progress.
          state_d = SHOW_ON;
          leds_d  = show_item;
          cnt_d   = speed ? LD_FAST : LD_SLOW;
        end
      end

      SHOW_ON: begin
        if (flash_req) begin
          state_d = FLASH_ON;
          leds_d  = '1;
          cnt_d   = LD_FLASH;
          pair_d  = PAIR_W'(1);
        end else if (expired) begin
          state_d = SHOW_GAP;
          leds_d  = '0;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end

      SHOW_GAP: begin
        if (flash_req) begin
          state_d = FLASH_ON;
          leds_d  = '1;
          cnt_d   = LD_FLASH;
          pair_d  = PAIR_W'(1);
        end else if (expired) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end

      FLASH_ON: begin
        if (expired) begin
          state_d = FLASH_OFF;
          leds_d  = '0;
          cnt_d   = LD_FLASH;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end

      FLASH_OFF: begin
        if (expired) begin
          // pair_q holds the number of pairs started so far.
          if (pair_q < PAIRS) begin
            state_d = FLASH_ON;
            leds_d  = '1;
            cnt_d   = LD_FLASH;
            pair_d  = pair_q + PAIR_W'(1);
          end else begin
            state_d = IDLE;
            pair_d  = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pair_d  = '0;
        leds_d  = '0;
      end
    endcase
  end

  assign show_ready = (state_q == IDLE);
  assign busy       = ~show_ready;
  assign done       = done_q;
  assign leds       = leds_q;

endmodule
